// File: rtl/midi_msg_decoder.sv
// midi_msg_decoder: byte-serial MIDI channel-message parser with running status.
// Valid/ready: there is no ready; a byte is consumed on every rising clk edge
// where valid_byte=1, so the block accepts one byte per cycle unconditionally.
module midi_msg_decoder (
   input  logic       clk,
   input  logic       rst,
   input  logic       valid_byte,
   input  logic [7:0] data,
   output logic       note_presse,
   output logic       note_release,
   output logic       note_keypress,
   output logic       pitch_wheel,
   output logic [6:0] note,
   output logic [6:0] velocity,
   output logic [3:0] channel,
   output logic       rst_cmd,
   output logic [7:0] addr
);

   // ST_IDLE: no valid running status, data bytes are dropped.
   // ST_DATA1/ST_DATA2: running status valid, waiting for data byte 1 or 2.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DATA1 = 2'd1,
      ST_DATA2 = 2'd2
   } state_t;

   state_t     state, state_next;
   logic [3:0] rs_type, rs_type_next;
   logic [3:0] rs_chan, rs_chan_next;
   logic [6:0] d1, d1_next;

   logic       note_presse_next, note_release_next, note_keypress_next;
   logic       pitch_wheel_next, rst_cmd_next;
   logic [6:0] note_next, velocity_next;
   logic [3:0] channel_next;
   logic [7:0] addr_next;

   logic       one_byte_type;

   // Program change and channel pressure carry a single data byte.
   assign one_byte_type = (rs_type == 4'hC) || (rs_type == 4'hD);

   // Parser state, running status and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         rs_type       <= 4'h0;
         rs_chan       <= 4'h0;
         d1            <= 7'h00;
         note_presse   <= 1'b0;
         note_release  <= 1'b0;
         note_keypress <= 1'b0;
         pitch_wheel   <= 1'b0;
         rst_cmd       <= 1'b0;
         note          <= 7'h00;
         velocity      <= 7'h00;
         channel       <= 4'h0;
         addr          <= 8'h00;
      end else begin
         state         <= state_next;
         rs_type       <= rs_type_next;
         rs_chan       <= rs_chan_next;
         d1            <= d1_next;
         note_presse   <= note_presse_next;
         note_release  <= note_release_next;
         note_keypress <= note_keypress_next;
         pitch_wheel   <= pitch_wheel_next;
         rst_cmd       <= rst_cmd_next;
         note          <= note_next;
         velocity      <= velocity_next;
         channel       <= channel_next;
         addr          <= addr_next;
      end
   end

   // Byte classification, next parser state and completion actions.
   always_comb begin
      state_next         = state;
      rs_type_next       = rs_type;
      rs_chan_next       = rs_chan;
      d1_next            = d1;
      note_presse_next   = 1'b0;
      note_release_next  = 1'b0;
      note_keypress_next = 1'b0;
      pitch_wheel_next   = 1'b0;
      rst_cmd_next       = 1'b0;
      note_next          = note;
      velocity_next      = velocity;
      channel_next       = channel;
      addr_next          = addr;

      if (valid_byte) begin
         if (data[7]) begin
            if (data < 8'hF0) begin
               // Channel status: new running status, any partial message dropped.
               state_next   = ST_DATA1;
               rs_type_next = data[7:4];
               rs_chan_next = data[3:0];
            end else if (data <= 8'hF7) begin
               state_next = ST_IDLE;
            end else if (data == 8'hFF) begin
               state_next   = ST_IDLE;
               rst_cmd_next = 1'b1;
            end
            // 0xF8-0xFE realtime: no effect at all.
         end else begin
            case (state)
               ST_DATA1: begin
                  if (one_byte_type) begin
                     // Message completes now; running status is kept.
                     if (rs_type == 4'hC) begin
                        addr_next    = {1'b0, data[6:0]};
                        channel_next = rs_chan;
                     end
                  end else begin
                     d1_next    = data[6:0];
                     state_next = ST_DATA2;
                  end
               end
               ST_DATA2: begin
                  state_next = ST_DATA1;
                  if (rs_type != 4'hB) begin
                     note_next     = d1;
                     velocity_next = data[6:0];
                     channel_next  = rs_chan;
                  end
                  case (rs_type)
                     4'h8: note_release_next = 1'b1;
                     4'h9: begin
                        if (data[6:0] == 7'h00) note_release_next = 1'b1;
                        else                    note_presse_next  = 1'b1;
                     end
                     4'hA:    note_keypress_next = 1'b1;
                     4'hE:    pitch_wheel_next   = 1'b1;
                     default: ;
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_midi_msg_decoder.sv
// tb_midi_msg_decoder: directed test-plan sequences plus random byte streams
// compared cycle by cycle against a queue-based MIDI message model.
module tb_midi_msg_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_byte = 1'b0;
  logic [7:0] data = 8'h00;
  logic       note_presse, note_release, note_keypress, pitch_wheel, rst_cmd;
  logic [6:0] note, velocity;
  logic [3:0] channel;
  logic [7:0] addr;

  int n_checks = 0;
  int n_errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  midi_msg_decoder dut (
    .clk(clk), .rst(rst), .valid_byte(valid_byte), .data(data),
    .note_presse(note_presse), .note_release(note_release),
    .note_keypress(note_keypress), .pitch_wheel(pitch_wheel),
    .note(note), .velocity(velocity), .channel(channel),
    .rst_cmd(rst_cmd), .addr(addr)
  );

  // reference model state
  bit         m_rs_valid;
  logic [7:0] m_status;
  logic [7:0] data_q[$];
  logic       e_presse, e_release, e_keypress, e_pitch, e_rst_cmd;
  logic [6:0] e_note, e_vel;
  logic [3:0] e_chan;
  logic [7:0] e_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rs_valid = 0; m_status = 8'h00; data_q.delete();
    e_presse = 0; e_release = 0; e_keypress = 0; e_pitch = 0; e_rst_cmd = 0;
    e_note = 0; e_vel = 0; e_chan = 0; e_addr = 0;
  endtask

  // What the decoder must show one cycle after sampling (v, b).
  task automatic model_step(input bit v, input logic [7:0] b);
    logic [3:0] kind;
    int need;
    e_presse = 0; e_release = 0; e_keypress = 0; e_pitch = 0; e_rst_cmd = 0;
    if (!v) return;
    if (b >= 8'h80 && b <= 8'hEF) begin
      m_rs_valid = 1; m_status = b; data_q.delete();
    end else if (b >= 8'hF0 && b <= 8'hF7) begin
      m_rs_valid = 0; data_q.delete();
    end else if (b == 8'hFF) begin
      m_rs_valid = 0; data_q.delete(); e_rst_cmd = 1;
    end else if (b < 8'h80 && m_rs_valid) begin
      data_q.push_back(b);
      kind = m_status[7:4];
      need = (kind == 4'hC || kind == 4'hD) ? 1 : 2;
      if (data_q.size() == need) begin
        if (kind == 4'hC) begin
          e_addr = {1'b0, data_q[0][6:0]}; e_chan = m_status[3:0];
        end else if (kind != 4'hB && kind != 4'hD) begin
          e_note = data_q[0][6:0]; e_vel = data_q[1][6:0]; e_chan = m_status[3:0];
          if (kind == 4'h8) e_release = 1;
          else if (kind == 4'h9) begin
            if (data_q[1] == 8'h00) e_release = 1; else e_presse = 1;
          end
          else if (kind == 4'hA) e_keypress = 1;
          else e_pitch = 1;
        end
        data_q.delete();
      end
    end
  endtask

  task automatic check_all();
    check("note_presse", note_presse, e_presse);
    check("note_release", note_release, e_release);
    check("note_keypress", note_keypress, e_keypress);
    check("pitch_wheel", pitch_wheel, e_pitch);
    check("rst_cmd", rst_cmd, e_rst_cmd);
    check("note", note, e_note);
    check("velocity", velocity, e_vel);
    check("channel", channel, e_chan);
    check("addr", addr, e_addr);
  endtask

  // driver: check outputs from the previous byte, then present the next one
  task automatic send_byte(input bit v, input logic [7:0] b);
    @(negedge clk);
    check_all();
    valid_byte = v; data = b;
    model_step(v, b);
  endtask

  task automatic send_seq(input logic [7:0] s[]);
    foreach (s[i]) send_byte(1'b1, s[i]);
    send_byte(1'b0, 8'h00);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    check_all();
    rst = 1'b1; valid_byte = 1'b0; data = 8'h00;
    model_reset();
    @(negedge clk);
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    int r;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    check("reset_note", note, 7'h00);
    rst = 1'b0;

    // Note On with explicit values
    send_seq('{8'h93, 8'h3C, 8'h64});
    check("tp1_presse", note_presse, 1'b1);
    check("tp1_note", note, 7'h3C);
    check("tp1_vel", velocity, 7'h64);
    check("tp1_chan", channel, 4'h3);
    send_byte(1'b0, 8'h00);
    check("tp1_one_cycle", note_presse, 1'b0);

    // running status, velocity-0 release
    send_seq('{8'h90, 8'h40, 8'h50, 8'h41, 8'h00});
    check("tp2_release", note_release, 1'b1);
    check("tp2_note", note, 7'h41);
    check("tp2_vel", velocity, 7'h00);

    // pitch bend then program change
    send_seq('{8'hE5, 8'h12, 8'h7F});
    check("tp3_pitch", pitch_wheel, 1'b1);
    check("tp3_vel", velocity, 7'h7F);
    send_seq('{8'hC2, 8'h05});
    check("tp3_addr", addr, 8'h05);
    check("tp3_chan", channel, 4'h2);

    // realtime inside a message, abort by new status
    send_seq('{8'h80, 8'h3C, 8'hF8, 8'h10});
    check("tp4_release", note_release, 1'b1);
    check("tp4_vel", velocity, 7'h10);
    send_seq('{8'h90, 8'h3C, 8'hA1, 8'h20, 8'h30});
    check("tp4_keypress", note_keypress, 1'b1);
    check("tp4_note", note, 7'h20);
    check("tp4_chan", channel, 4'h1);

    // SysEx discard, system reset command, data after it ignored
    send_seq('{8'hF0, 8'h7E, 8'h01, 8'hF7, 8'h40});
    check("tp5_addr_hold", addr, 8'h05);
    send_byte(1'b1, 8'hFF);
    send_byte(1'b0, 8'h00);
    check("tp5_rst_cmd", rst_cmd, 1'b1);
    send_seq('{8'h40, 8'h40});
    check("tp5_no_strobe", note_presse | note_release, 1'b0);

    // reset in the middle of a message
    send_byte(1'b1, 8'h90);
    pulse_reset();
    send_seq('{8'h3C, 8'h64});
    check("tp6_no_strobe", note_presse, 1'b0);
    check("tp6_note", note, 7'h00);
    check("tp6_addr", addr, 8'h00);

    // random streams, back-to-back bytes mostly
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      send_byte(1'b1, 8'($urandom_range(0, 127)));
      else if (r < 75) send_byte(1'b1, 8'($urandom_range(8'h80, 8'hEF)));
      else if (r < 80) send_byte(1'b1, 8'($urandom_range(8'hF0, 8'hF7)));
      else if (r < 86) send_byte(1'b1, 8'($urandom_range(8'hF8, 8'hFE)));
      else if (r < 88) send_byte(1'b1, 8'hFF);
      else if (r < 99) send_byte(1'b0, 8'($urandom_range(0, 255)));
      else             pulse_reset();
    end
    send_byte(1'b0, 8'h00);
    @(negedge clk);
    check_all();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
